snn_ctrl: RTL
=============

SNN_CTRL -- requirements
Module: snn_ctrl

Interface
REQ-001 SHALL have parameter NUM_BYTES, 98, image bytes per frame (784 pixels / 8).
REQ-002 SHALL have parameter ADDR_W, 10, RAM address width.
REQ-003 SHALL have port clk  input  1  system clock; one clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_rdy  input  1  one-cycle pulse: UART byte valid.
REQ-006 SHALL have port rx_data  input  8  received byte, valid with rx_rdy.
REQ-007 SHALL have port done  input  1  snn_core digit ready pulse.
REQ-008 SHALL have port digit  input  4  snn_core result, valid with done.
REQ-009 SHALL have port core_addr  input  ADDR_W  snn_core input-RAM read address.
REQ-010 SHALL have port tx_rdy  input  1  UART transmitter idle.
REQ-011 SHALL have port ram_we  output  1  input-RAM write enable.
REQ-012 SHALL have port ram_addr  output  ADDR_W  input-RAM address (muxed).
REQ-013 SHALL have port ram_wdata  output  1  pixel bit written.
REQ-014 SHALL have port start  output  1  one-cycle snn_core start pulse.
REQ-015 SHALL have port tx_start  output  1  one-cycle UART transmit request.
REQ-016 SHALL have port tx_data  output  8  byte to transmit.
REQ-017 SHALL have port busy  output  1  high in every state except LOAD.
REQ-018 SHALL have port overrun  output  1  sticky: byte arrived while holding register full.

Function
REQ-019 SHALL implement states LOAD, UNPACK, START, CALC, TX_WAIT, TX.
REQ-020 LOAD: on rx_rdy SHALL capture rx_data into 8-bit hold register, set hold_full, go UNPACK next cycle.
REQ-021 UNPACK SHALL last exactly 8 cycles, writing bit b (LSB first, b=0..7) to address byte_cnt*8+b with ram_we=1.
REQ-022 After bit 7 SHALL clear hold_full, increment byte_cnt; if byte_cnt reaches NUM_BYTES go START, else LOAD.
REQ-023 START SHALL assert start for exactly one cycle, then enter CALC.
REQ-024 CALC SHALL drive ram_addr=core_addr, ram_we=0; on done SHALL latch digit and go TX_WAIT.
REQ-025 TX_WAIT SHALL wait for tx_rdy=1, then enter TX.
REQ-026 TX SHALL assert tx_start one cycle with tx_data stable, clear byte_cnt, return to LOAD.
REQ-027 tx_data SHALL hold its value from TX entry until next TX.
REQ-028 ram_addr SHALL equal byte_cnt*8+bit_cnt in LOAD/UNPACK and core_addr otherwise; ram_we SHALL be 0 outside UNPACK.
REQ-029 rx_rdy during UNPACK with hold_full SHALL set overrun and drop the byte; rx_rdy outside LOAD/UNPACK SHALL be ignored without flagging.
REQ-030 done outside CALC SHALL be ignored.
REQ-031 Frame-to-result latency: start SHALL assert 2 cycles after the last UNPACK write.
REQ-032 byte_cnt SHALL be 7 bits; maximum written address 783 (0x30F), no wrap.

Reset
REQ-033 rst_n low SHALL force state LOAD, byte_cnt=0, bit_cnt=0, hold_full=0, overrun=0, tx_data=8'h00, all strobes 0, asynchronously, including mid-frame or mid-CALC.
REQ-034 After reset, a partially loaded frame SHALL be discarded; loading restarts at address 0.

Configuration
REQ-035 With SNN_CTRL_ASCII_EN defined, tx_data SHALL be 8'h30+digit (ASCII '0'..'9').
REQ-036 Without SNN_CTRL_ASCII_EN, tx_data SHALL be {4'h0,digit}.

Structure
REQ-037 State enum, NUM_BYTES default, IMG_BITS=784 and ASCII_ZERO=8'h30 SHALL reside in package snn_pkg.
REQ-038 Unpack counter/address generator SHALL be sub-module snn_unpack_cnt (bit_cnt, byte_cnt, address output).

Verification
REQ-039 98 bytes 8'hA5 -> 784 writes, address n gets bit n%8 of 8'hA5 (1,0,1,0,0,1,0,1), then one start pulse.
REQ-040 done with digit=7, tx_rdy=1 -> tx_start one pulse, tx_data=8'h37 (ASCII) or 8'h07 (non-ASCII).
REQ-041 tx_rdy held low 100 cycles after done -> no tx_start until tx_rdy rises; then exactly one.
REQ-042 rx_rdy pulse on UNPACK cycle 3 -> overrun=1, byte dropped, byte_cnt advances once.
REQ-043 rst_n low after byte 50 -> all outputs reset values; next 98 bytes start at address 0 and complete normally.
REQ-044 done pulse during LOAD -> no state change, no tx_start.

Source files
------------

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared states, frame constants and result formatting for snn_ctrl
package snn_pkg;

  localparam int         IMG_BITS      = 784;
  localparam int         NUM_BYTES_DEF = IMG_BITS / 8;
  localparam int         BYTE_CNT_W    = 7;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;

  typedef enum logic [2:0] {
    LOAD,
    UNPACK,
    START,
    CALC,
    TX_WAIT,
    TX
  } snn_state_e;

  function automatic logic [7:0] fmt_digit(input logic [3:0] d, input logic ascii);
    fmt_digit = ascii ? (ASCII_ZERO + {4'h0, d}) : {4'h0, d};
  endfunction

endpackage

// File: rtl/snn_unpack_cnt.sv
// rtl/snn_unpack_cnt.sv - bit/byte counters and input-RAM write address for pixel unpacking
module snn_unpack_cnt
  import snn_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step_i,
  input  logic                  clr_i,
  output logic [2:0]            bit_cnt_o,
  output logic [BYTE_CNT_W-1:0] byte_cnt_o,
  output logic [ADDR_W-1:0]     addr_o
);

  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (clr_i) begin
      bit_cnt_d  = 3'd0;
      byte_cnt_d = '0;
    end else if (step_i) begin
      // bit_cnt wraps 7 -> 0 on its own; the byte counter follows on that wrap
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_cnt_d = byte_cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign bit_cnt_o  = bit_cnt_q;
  assign byte_cnt_o = byte_cnt_q;
  assign addr_o     = ADDR_W'({byte_cnt_q, bit_cnt_q});

endmodule

// File: rtl/snn_ctrl.sv
// rtl/snn_ctrl.sv - UART-to-snn_core frame controller: unpack pixels, start core, send digit.
// Define SNN_CTRL_ASCII_EN to transmit the digit as ASCII '0'..'9' instead of a raw nibble.
module snn_ctrl
  import snn_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic              done,
  input  logic [3:0]        digit,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              tx_rdy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              start,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              overrun
);

`ifdef SNN_CTRL_ASCII_EN
  localparam logic ASCII_EN = 1'b1;
`else
  localparam logic ASCII_EN = 1'b0;
`endif

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(NUM_BYTES - 1);

  snn_state_e state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       overrun_q, overrun_d;
  logic [3:0] digit_q, digit_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       start_q, start_d;

  logic [2:0]            bit_cnt;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [ADDR_W-1:0]     cnt_addr;

  snn_unpack_cnt #(
    .ADDR_W(ADDR_W)
  ) u_unpack_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_i    (state_q == UNPACK),
    .clr_i     (state_q == TX),
    .bit_cnt_o (bit_cnt),
    .byte_cnt_o(byte_cnt),
    .addr_o    (cnt_addr)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    digit_d     = digit_q;
    tx_data_d   = tx_data_q;
    start_d     = 1'b0;
    ram_we      = 1'b0;
    ram_wdata   = 1'b0;
    ram_addr    = core_addr;
    tx_start    = 1'b0;

    case (state_q)
      LOAD: begin
        ram_addr = cnt_addr;
        if (rx_rdy) begin
          hold_d      = rx_data;
          hold_full_d = 1'b1;
          state_d     = UNPACK;
        end
      end
      UNPACK: begin
        ram_addr  = cnt_addr;
        ram_we    = 1'b1;
        ram_wdata = hold_q[bit_cnt];
        // the hold register is still being drained, so a new byte is lost
        if (rx_rdy && hold_full_q) begin
          overrun_d = 1'b1;
        end
        if (bit_cnt == 3'd7) begin
          hold_full_d = 1'b0;
          state_d     = (byte_cnt == LAST_BYTE) ? START : LOAD;
        end
      end
      START: begin
        start_d = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        if (done) begin
          digit_d = digit;
          state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_rdy) begin
          tx_data_d = fmt_digit(digit_q, ASCII_EN);
          state_d   = TX;
        end
      end
      TX: begin
        tx_start = 1'b1;
        state_d  = LOAD;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      digit_q     <= 4'h0;
      tx_data_q   <= 8'h00;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      digit_q     <= digit_d;
      tx_data_q   <= tx_data_d;
      start_q     <= start_d;
    end
  end

  // start is registered so it lands two cycles after the final pixel write
  assign start   = start_q;
  assign tx_data = tx_data_q;
  assign busy    = (state_q != LOAD);
  assign overrun = overrun_q;

endmodule
